// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor.
// Holds the FSM state encoding, the add/sub mode constants and small helpers
// used by the top module and by anything that drives or checks it.
package multicycle_adder_pkg;

  // FSM state encoding shared with the ALU control sequencer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Value of the sub input that selects each mode.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  // Two's-complement overflow: same-sign operands giving an opposite-sign sum.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/multicycle_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder.
// Each bit is one full-adder cell; the carry ripples LSB to MSB.
// Ports:
//   sum [CHUNK] - x + y + ci, low CHUNK bits
//   co          - carry out of the MSB cell
//   x, y [CHUNK]- addends
//   ci          - carry into the LSB cell
module multicycle_adder_chunk_adder #(
  parameter int unsigned CHUNK = 8
) (
  output logic [CHUNK-1:0] sum,
  output logic             co,
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci
);

  // Ripple chain held in a procedural variable so the carry does not form a
  // self-referencing vector across bits.
  always_comb begin
    logic c;
    sum = '0;
    c   = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per
// clock, carrying between chunks in a register, with start/busy/done handshake.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - request an operation (accepted in IDLE or DONE)
//   sub            - 0: a + b + cin, 1: a - b (cin ignored)
//   cin            - carry-in for add mode
//   a, b [WIDTH]   - operands, latched when start is accepted
//   busy           - high while chunks are being processed
//   done           - one-cycle pulse when s/cout/ovf are final
//   s [WIDTH]      - result register (partial while busy)
//   cout           - final carry-out (sub: 1 = no borrow)
//   ovf            - signed overflow
// WIDTH must be a multiple of CHUNK.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] x_c, y_c, sum_c;
  logic             co_c;
  logic             accept_c;
  logic             last_c;

  // A start is taken whenever the unit is not mid-operation.
  assign accept_c = start && (state_q != ST_RUN);
  assign last_c   = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Select the operand chunks addressed by the chunk counter.
  always_comb begin
    x_c = '0;
    y_c = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        x_c = a_q[i*CHUNK +: CHUNK];
        y_c = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  multicycle_adder_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .sum (sum_c),
    .co  (co_c),
    .x   (x_c),
    .y   (y_c),
    .ci  (carry_q)
  );

  // Output and datapath next values.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);

    if (accept_c) begin
      // Subtraction is a + ~b + 1: invert B once here and seed the carry.
      a_d     = a;
      b_d     = (sub == MODE_SUB) ? ~b : b;
      carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
      cnt_d   = '0;
      s_d     = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          s_d[i*CHUNK +: CHUNK] = sum_c;
        end
      end
      carry_d = co_c;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_c) begin
        // The top chunk's sum MSB is the result sign bit.
        cout_d = co_c;
        ovf_d  = signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_c[CHUNK-1]);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three 8-bit instances with CHUNK = 4, 8 and 1
// run a table of hand-computed vectors, then directed handshake sequences.
module tb_multicycle_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a   = '0;
  logic [7:0] b   = '0;
  logic [2:0] start = '0;
  logic [2:0] busy, done, cout, ovf;
  logic [7:0] s [3];

  int errors = 0;
  int checks = 0;
  int nch [3] = '{2, 1, 8};

  always #5 clk = ~clk;

  multicycle_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start[0]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy[0]), .done(done[0]), .s(s[0]), .cout(cout[0]), .ovf(ovf[0]));

  multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(start[1]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy[1]), .done(done[1]), .s(s[1]), .cout(cout[1]), .ovf(ovf[1]));

  multicycle_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start[2]), .sub(sub), .cin(cin), .a(a), .b(b),
    .busy(busy[2]), .done(done[2]), .s(s[2]), .cout(cout[2]), .ovf(ovf[2]));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one operation on instance k and wait (bounded) for its done pulse.
  // n returns the number of edges from acceptance to done.
  task automatic run_op(input int k, input logic [7:0] va, input logic [7:0] vb,
                        input logic vsub, input logic vcin, output int n);
    @(negedge clk);
    a = va; b = vb; sub = vsub; cin = vcin;
    start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    chk($sformatf("busy_after_accept k%0d", k), 32'(busy[k]), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done[k] && n < 40);
  endtask

  initial begin
    int n;
    int dn1, dn2, dcount;
    logic [7:0] s_d1, s_d2;
    logic ovf_d2;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};

    // Reset state on every instance.
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_s k%0d", k),    32'(s[k]),    32'h0);
      chk($sformatf("rst_busy k%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_done k%0d", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst_cout k%0d", k), 32'(cout[k]), 32'd0);
      chk($sformatf("rst_ovf k%0d", k),  32'(ovf[k]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table vectors on all three chunk sizes.
    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < 3; k++) begin
        run_op(k, vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].cin, n);
        chk($sformatf("latency v%0d k%0d", v, k), 32'(n), 32'(nch[k]));
        chk($sformatf("s v%0d k%0d", v, k),    32'(s[k]),    32'(vecs[v].s));
        chk($sformatf("cout v%0d k%0d", v, k), 32'(cout[k]), 32'(vecs[v].cout));
        chk($sformatf("ovf v%0d k%0d", v, k),  32'(ovf[k]),  32'(vecs[v].ovf));
        chk($sformatf("busy_at_done v%0d k%0d", v, k), 32'(busy[k]), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("done_one_cycle v%0d k%0d", v, k), 32'(done[k]), 32'd0);
        chk($sformatf("s_hold v%0d k%0d", v, k), 32'(s[k]), 32'(vecs[v].s));
      end
    end

    // Start pulsed mid-RUN with other operands is ignored.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; sub = 1'b1; cin = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 1;
    while (!done[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midrun_latency", 32'(n), 32'd2);
    chk("midrun_s", 32'(s[0]), 32'h10);
    chk("midrun_ovf", 32'(ovf[0]), 32'd0);
    @(posedge clk); #1;
    chk("midrun_no_restart", 32'(busy[0]), 32'd0);

    // Start held through DONE: back-to-back with no IDLE cycle.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; sub = 1'b0; cin = 1'b0; start[0] = 1'b1;
    dn1 = -1; dn2 = -1; s_d1 = '0; s_d2 = '0; ovf_d2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin a = 8'h7F; b = 8'h01; end
      if (c == 3) chk("b2b_busy_no_idle", 32'(busy[0]), 32'd1);
      if (c == 4) start[0] = 1'b0;
      if (done[0]) begin
        if (dn1 < 0) begin dn1 = c; s_d1 = s[0]; end
        else if (dn2 < 0) begin dn2 = c; s_d2 = s[0]; ovf_d2 = ovf[0]; end
      end
    end
    chk("b2b_first_done", 32'(dn1), 32'd2);
    chk("b2b_second_done", 32'(dn2), 32'd5);
    chk("b2b_first_s", 32'(s_d1), 32'h10);
    chk("b2b_second_s", 32'(s_d2), 32'h80);
    chk("b2b_second_ovf", 32'(ovf_d2), 32'd1);

    // Reset in the middle of a CHUNK=1 run.
    @(negedge clk);
    a = 8'h0F; b = 8'h00; sub = 1'b0; cin = 1'b0; start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("partial_s", 32'(s[2]), 32'h07);
    chk("partial_busy", 32'(busy[2]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_s", 32'(s[2]), 32'h0);
    chk("midrst_busy", 32'(busy[2]), 32'd0);
    chk("midrst_done", 32'(done[2]), 32'd0);
    chk("midrst_cout", 32'(cout[2]), 32'd0);
    chk("midrst_ovf", 32'(ovf[2]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done[2] || busy[2]) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);
    run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0, n);
    chk("after_rst_latency", 32'(n), 32'd8);
    chk("after_rst_s", 32'(s[2]), 32'h80);
    chk("after_rst_ovf", 32'(ovf[2]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
